// File: rtl/param_updown_counter_pkg.sv
// Shared types and constants for the parametrised up/down counter.
package param_updown_counter_pkg;

  // Width of the datapath bus the counter ports sit on.
  localparam int BUS_W = 8;

  // Control FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/param_updown_counter_next_value.sv
// Combinational bound arithmetic: next count plus terminal/saturate flags.
module counter_next_value #(
  parameter int UUID     = 0,
  parameter int W        = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic [W-1:0] count,
  input  logic [W-1:0] limit,
  input  logic         down,
  output logic [W-1:0] next_count,
  output logic         term,      // a wrap was applied, or a saturating bound was hit
  output logic         sat_hit    // saturate mode: this step lands on (or stays at) the bound
);

  if (W < 1) begin : g_bad_w
    $error("counter_next_value (uuid %0d): W must be at least 1", UUID);
  end

  logic wrap;

  // Bound handling: up counts wrap/clamp at limit (anything above limit counts
  // as past the bound), down counts wrap/clamp at zero.
  always_comb begin
    next_count = count;
    wrap       = 1'b0;
    sat_hit    = 1'b0;
    if (!down) begin
      if (count >= limit) begin
        next_count = SATURATE ? limit : '0;
        wrap       = !SATURATE;
        sat_hit    = SATURATE;
      end else begin
        next_count = count + 1'b1;
        sat_hit    = SATURATE && ((count + 1'b1) == limit);
      end
    end else begin
      if (count == '0) begin
        next_count = SATURATE ? '0 : limit;
        wrap       = !SATURATE;
        sat_hit    = SATURATE;
      end else begin
        next_count = count - 1'b1;
        sat_hit    = SATURATE && (count == W'(1));
      end
    end
  end

  assign term = wrap | sat_hit;

endmodule

// File: rtl/param_updown_counter.sv
// WIDTH-bit up/down counter with load, programmable limit, wrap or saturate
// mode, registered terminal pulse and a RUN/IDLE/HALT control FSM.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int    UUID     = 0,
  parameter string NAME     = "",
  parameter int    WIDTH    = 8,
  parameter bit    SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] Overrite_Value,
  input  logic             Overrite,
  input  logic             Enable,
  input  logic             Down,
  input  logic [BUS_W-1:0] Limit,
  output logic [BUS_W-1:0] Output,
  output logic             Terminal,
  output logic             Busy
);

  if (WIDTH < 2 || WIDTH > BUS_W) begin : g_bad_width
    $error("param_updown_counter %s (uuid %0d): WIDTH must be 2..%0d", NAME, UUID, BUS_W);
  end

  // Upper bus bits are deliberately ignored on input.
  if (WIDTH < BUS_W) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^{Overrite_Value[BUS_W-1:WIDTH], Limit[BUS_W-1:WIDTH]};
  end

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] next_count;
  logic             step_term;
  logic             sat_hit;
  logic             away;
  state_t           state;

  assign lim = Limit[WIDTH-1:0];

  counter_next_value #(
    .UUID     (UUID ^ 1),
    .W        (WIDTH),
    .SATURATE (SATURATE)
  ) u_next (
    .count      (count),
    .limit      (lim),
    .down       (Down),
    .next_count (next_count),
    .term       (step_term),
    .sat_hit    (sat_hit)
  );

  // In HALT, a direction pointing off the bound we are parked on releases the FSM.
  assign away = Down ? (count != '0) : (count != lim);

  // Control FSM, count register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      Terminal <= 1'b0;
      Busy     <= 1'b0;
      state    <= IDLE;
    end else if (Overrite) begin
      count    <= Overrite_Value[WIDTH-1:0];
      Terminal <= 1'b0;
      Busy     <= 1'b0;
      state    <= IDLE;
    end else begin
      Terminal <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (Enable) begin
            count    <= next_count;
            Terminal <= step_term;
            // A saturating hit parks immediately so the bound is not re-flagged.
            if (sat_hit) begin
              state <= HALT;
              Busy  <= 1'b0;
            end else begin
              state <= RUN;
              Busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        HALT: begin
          Busy <= 1'b0;
          if (away) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Output = BUS_W'(count);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: one wrap-mode and one saturate-mode WIDTH=4 counter on shared stimulus.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ov;
  logic       ovr;
  logic       en;
  logic       dn;
  logic [7:0] lim;
  logic [7:0] w_out, s_out;
  logic       w_term, s_term, w_busy, s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.UUID(1), .NAME("wrap4"), .WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .Overrite_Value(ov), .Overrite(ovr), .Enable(en),
    .Down(dn), .Limit(lim), .Output(w_out), .Terminal(w_term), .Busy(w_busy)
  );

  param_updown_counter #(.UUID(2), .NAME("sat4"), .WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .Overrite_Value(ov), .Overrite(ovr), .Enable(en),
    .Down(dn), .Limit(lim), .Output(s_out), .Terminal(s_term), .Busy(s_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_w [12];
    exp_w = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    rst = 1'b1; ov = 8'h00; ovr = 1'b0; en = 1'b1; dn = 1'b0; lim = 8'hF9;

    // Reset held two cycles with Enable high
    step(); step();
    chk("rst_out", w_out, 8'h00);
    chk("rst_term", {7'd0, w_term}, 8'h00);
    chk("rst_busy", {7'd0, w_busy}, 8'h00);
    chk("rst_sat_out", s_out, 8'h00);

    // Wrap up-count, Limit=9 (upper Limit bits ignored)
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("wrap_up_out%0d", i), w_out, 8'(exp_w[i]));
      chk($sformatf("wrap_up_term%0d", i), {7'd0, w_term}, (i == 9) ? 8'h01 : 8'h00);
    end
    chk("wrap_up_busy", {7'd0, w_busy}, 8'h01);

    // Load beats Enable; upper load bits dropped
    ov = 8'h37; ovr = 1'b1;
    step();
    chk("load_out", w_out, 8'h07);
    chk("load_term", {7'd0, w_term}, 8'h00);
    chk("load_busy", {7'd0, w_busy}, 8'h00);

    // Loading a value equal to Limit does not flag Terminal
    ov = 8'h09;
    step();
    chk("load_lim_out", w_out, 8'h09);
    chk("load_lim_term", {7'd0, w_term}, 8'h00);
    ovr = 1'b0;
    step();
    chk("post_load_wrap_out", w_out, 8'h00);
    chk("post_load_wrap_term", {7'd0, w_term}, 8'h01);

    // Saturate: Limit=5, load 3, count up
    rst = 1'b1; step();
    rst = 1'b0; lim = 8'h05; ov = 8'h03; ovr = 1'b1; en = 1'b0;
    step();
    chk("sat_load", s_out, 8'h03);
    ovr = 1'b0; en = 1'b1;
    step();
    chk("sat_up1", s_out, 8'h04);
    chk("sat_up1_term", {7'd0, s_term}, 8'h00);
    chk("sat_up1_busy", {7'd0, s_busy}, 8'h01);
    step();
    chk("sat_up2", s_out, 8'h05);
    chk("sat_up2_term", {7'd0, s_term}, 8'h01);
    chk("sat_halt_busy", {7'd0, s_busy}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("sat_hold%0d", i), s_out, 8'h05);
      chk($sformatf("sat_hold_term%0d", i), {7'd0, s_term}, 8'h00);
      chk($sformatf("sat_hold_busy%0d", i), {7'd0, s_busy}, 8'h00);
    end

    // Reverse out of HALT: one edge to leave HALT, then counting resumes
    dn = 1'b1;
    step();
    chk("sat_rel_out", s_out, 8'h05);
    chk("sat_rel_busy", {7'd0, s_busy}, 8'h00);
    step();
    chk("sat_dn4", s_out, 8'h04);
    chk("sat_dn4_busy", {7'd0, s_busy}, 8'h01);
    step(); step(); step();
    chk("sat_dn1", s_out, 8'h01);
    step();
    chk("sat_dn0", s_out, 8'h00);
    chk("sat_dn0_term", {7'd0, s_term}, 8'h01);
    step();
    chk("sat_dn0_hold", s_out, 8'h00);
    chk("sat_dn0_hold_term", {7'd0, s_term}, 8'h00);

    // Wrap down from 1 with Limit=9, then reverse mid-run
    lim = 8'h09; ov = 8'h01; ovr = 1'b1; en = 1'b0;
    step();
    ovr = 1'b0; en = 1'b1;
    step();
    chk("wdn_0", w_out, 8'h00);
    chk("wdn_0_term", {7'd0, w_term}, 8'h00);
    step();
    chk("wdn_9", w_out, 8'h09);
    chk("wdn_9_term", {7'd0, w_term}, 8'h01);
    step();
    chk("wdn_8", w_out, 8'h08);
    dn = 1'b0;
    step();
    chk("wrev_9", w_out, 8'h09);
    chk("wrev_9_term", {7'd0, w_term}, 8'h00);
    step();
    chk("wrev_0", w_out, 8'h00);
    chk("wrev_0_term", {7'd0, w_term}, 8'h01);

    // Reset mid-count at 6
    ov = 8'h05; ovr = 1'b1;
    step();
    ovr = 1'b0;
    step();
    chk("mid_6", w_out, 8'h06);
    rst = 1'b1;
    step();
    chk("mid_rst_out", w_out, 8'h00);
    chk("mid_rst_term", {7'd0, w_term}, 8'h00);
    chk("mid_rst_busy", {7'd0, w_busy}, 8'h00);

    // Limit=0: constant 0; wrap flags every enabled cycle, saturate only once
    rst = 1'b0; lim = 8'h00; dn = 1'b0; en = 1'b1;
    step();
    chk("l0_w_out1", w_out, 8'h00);
    chk("l0_w_term1", {7'd0, w_term}, 8'h01);
    chk("l0_s_term1", {7'd0, s_term}, 8'h01);
    step();
    chk("l0_w_term2", {7'd0, w_term}, 8'h01);
    chk("l0_s_term2", {7'd0, s_term}, 8'h00);
    dn = 1'b1;
    step();
    chk("l0_w_dn_out", w_out, 8'h00);
    chk("l0_w_dn_term", {7'd0, w_term}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
